bcd2bin: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble: one bit is shifted out per clock, with a per-digit "subtract 3" correction.
- Counterpart to the team's serial binary-to-BCD block. Turns keypad/display-domain BCD values (scores, timer presets) back into binary for arithmetic logic.
- Start/busy/valid handshake. Flags malformed digits instead of converting them.

---
 rtl/bcd2bin.sv | 119 +++++++++++
 tb/tb_bcd2bin.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// Serial BCD-to-binary converter (reverse double-dabble).
// Each conversion shifts one bit per clock. Words that contain a malformed digit are rejected with an err pulse.
module bcd2bin #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned SR_W  = BCD_W + BIN_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   digits, digits_nxt;
    logic [BIN_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIN_W-1:0]   bin_nxt;
    logic               valid_nxt, busy_nxt, err_nxt;

    logic               bad_digit_c;
    logic [SR_W-1:0]    shifted_c;
    logic [BCD_W-1:0]   corrected_c;

    // Any nibble above 9 makes the word illegal.
    always_comb begin
        bad_digit_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) bad_digit_c = 1'b1;
        end
    end

    // One shift step. A shifted digit >= 8 has its top bit set and gets 3 subtracted from it.
    always_comb begin
        shifted_c = {digits, acc} >> 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shifted_c[BIN_W + 4*i + 3])
                corrected_c[4*i +: 4] = shifted_c[BIN_W + 4*i +: 4] - 4'd3;
            else
                corrected_c[4*i +: 4] = shifted_c[BIN_W + 4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        digits_nxt = digits;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        bin_nxt    = bin_out;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        busy_nxt   = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_digit_c) begin
                        err_nxt = 1'b1;
                    end else begin
                        digits_nxt = bcd_in;
                        acc_nxt    = '0;
                        cnt_nxt    = CNT_W'(BIN_W);
                        busy_nxt   = 1'b1;
                        state_nxt  = CONV;
                    end
                end
            end
            CONV: begin
                digits_nxt = corrected_c;
                acc_nxt    = shifted_c[BIN_W-1:0];
                cnt_nxt    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    bin_nxt   = shifted_c[BIN_W-1:0];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits  <= '0;
            acc     <= '0;
            cnt     <= '0;
            bin_out <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            digits  <= digits_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            bin_out <= bin_nxt;
            valid   <= valid_nxt;
            busy    <= busy_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin.
// The bench computes each expected result as the decimal value of the BCD digits.
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd_in;
    logic [9:0]  bin_out;
    logic        valid, busy, err;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_bin = '0;

    bcd2bin #(.DIGITS(3), .BIN_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .bin_out(bin_out), .valid(valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: returns the decimal value of the BCD word, or -1 if any digit is greater than 9.
    function automatic int ref_value(input logic [11:0] w);
        int v = 0;
        for (int i = 2; i >= 0; i--) begin
            if (w[4*i +: 4] > 4'd9) return -1;
            v = v * 10 + int'(w[4*i +: 4]);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one conversion and waits for valid. lat is the number of cycles from E0 to valid (20 means timeout).
    task automatic run_conv(input logic [11:0] w, output int lat, output int busy_n, output int err_n);
        start = 1'b1;
        bcd_in = w;
        tick();
        start = 1'b0;
        busy_n = int'(busy);
        err_n = int'(err);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            err_n += int'(err);
            if (valid) break;
            busy_n += int'(busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; bcd_in = '0;
        #12;
        checks++;
        if ({bin_out, valid, busy, err} !== 13'd0) begin
            errors++;
            $display("FAIL reset: got bin=%0d v=%0b b=%0b e=%0b, want all zero", bin_out, valid, busy, err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_999();
        int lat, bn, en;
        run_conv(12'h999, lat, bn, en);
        exp_bin = 10'd999;
        checks++;
        if (bin_out !== exp_bin || lat != 10) begin
            errors++;
            $display("FAIL conv_999: got %0d lat %0d, want %0d lat 10", bin_out, lat, exp_bin);
        end
        checks++;
        if (bn != 10 || en != 0) begin
            errors++;
            $display("FAIL busy_999: busy cycles %0d err %0d, want 10 and 0", bn, en);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_999: valid=%0b busy=%0b after pulse, want 0 0", valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] seq [3] = '{12'h000, 12'h256, 12'h010};
        int want [3] = '{0, 256, 10};
        int gap;
        start = 1'b1;
        bcd_in = seq[0];
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            while (gap < 30) begin
                tick();
                gap++;
                if (valid) break;
            end
            checks++;
            if (int'(bin_out) != want[k] || gap != 11) begin
                errors++;
                $display("FAIL b2b_%0d: got %0d gap %0d, want %0d gap 11", k, bin_out, gap, want[k]);
            end
            if (k < 2) bcd_in = seq[k+1];
            else start = 1'b0;
        end
        exp_bin = 10'd10;
        tick();
    endtask

    task automatic test_err();
        int nv = 0;
        start = 1'b1;
        bcd_in = 12'h1A3;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%0b busy=%0b valid=%0b, want 1 0 0", err, busy, valid);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_width: err=%0b on second cycle, want 0", err);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            nv += int'(valid) + int'(busy);
        end
        checks++;
        if (nv != 0 || bin_out !== exp_bin) begin
            errors++;
            $display("FAIL err_hold: bin=%0d activity=%0d, want %0d and 0", bin_out, nv, exp_bin);
        end
    endtask

    task automatic test_ignore_start();
        int cyc = 0, nv = 0, ne = 0;
        start = 1'b1;
        bcd_in = 12'h123;
        tick();
        start = 1'b0;
        tick(); tick();
        bcd_in = 12'h999;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            cyc++;
            nv += int'(valid);
            ne += int'(err);
            if (valid && nv == 1) begin
                checks++;
                if (bin_out !== 10'd123) begin
                    errors++;
                    $display("FAIL ignore_val: got %0d, want 123", bin_out);
                end
            end
        end
        exp_bin = 10'd123;
        checks++;
        if (nv != 1 || ne != 0) begin
            errors++;
            $display("FAIL ignore_count: valid pulses %0d err %0d, want 1 and 0", nv, ne);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0, lat, bn, en;
        start = 1'b1;
        bcd_in = 12'h500;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bin_out, valid, busy, err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid: bin=%0d v=%0b b=%0b e=%0b, want all zero", bin_out, valid, busy, err);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            nv += int'(valid) + int'(busy);
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL reset_abort: activity %0d after reset, want 0", nv);
        end
        run_conv(12'h042, lat, bn, en);
        exp_bin = 10'd42;
        checks++;
        if (bin_out !== exp_bin || lat != 10) begin
            errors++;
            $display("FAIL reset_restart: got %0d lat %0d, want 42 lat 10", bin_out, lat);
        end
    endtask

    task automatic test_sweep();
        int lat, bn, en;
        for (int d = 0; d < 1000; d++) begin
            logic [11:0] w;
            w = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            run_conv(w, lat, bn, en);
            exp_bin = 10'(ref_value(w));
            checks++;
            if (bin_out !== exp_bin || lat != 10 || en != 0) begin
                errors++;
                $display("FAIL sweep_%03h: got %0d lat %0d err %0d, want %0d lat 10", w, bin_out, lat, en, exp_bin);
            end
        end
    endtask

    task automatic test_random();
        int lat, bn, en, r;
        logic [11:0] w;
        for (int n = 0; n < 300; n++) begin
            w = 12'($urandom);
            if ($urandom_range(3, 0) != 0) begin
                for (int i = 0; i < 3; i++)
                    if (w[4*i +: 4] > 4'd9) w[4*i +: 4] = 4'($urandom_range(9, 0));
            end
            r = ref_value(w);
            if (r < 0) begin
                start = 1'b1;
                bcd_in = w;
                tick();
                start = 1'b0;
                checks++;
                if (err !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || bin_out !== exp_bin) begin
                    errors++;
                    $display("FAIL rand_bad_%03h: err=%0b busy=%0b valid=%0b bin=%0d, want 1 0 0 %0d",
                             w, err, busy, valid, bin_out, exp_bin);
                end
                tick();
            end else begin
                run_conv(w, lat, bn, en);
                exp_bin = 10'(r);
                checks++;
                if (bin_out !== exp_bin || lat != 10 || en != 0) begin
                    errors++;
                    $display("FAIL rand_%03h: got %0d lat %0d, want %0d lat 10", w, bin_out, lat, exp_bin);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_999();
        test_back_to_back();
        test_err();
        test_ignore_start();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
